// File: rtl/regfile_mp_sb.sv
// Multi-port register file with optional write-to-read bypass and a busy-bit
// scoreboard for RAW/WAW hazard detection at decode.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 1 << ADDR_WIDTH,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         alloc_valid,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    output logic                         alloc_ready,
    output logic [ADDR_WIDTH:0]          busy_count,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_WR-1:0]     wr_ok;
    logic                  alloc_zero;
    logic                  alloc_acc;

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [NUM_REGS-1:0] b);
        logic [ADDR_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, b[i]};
        return cnt;
    endfunction

    // Writes to x0 are dropped entirely when x0 is hardwired.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NUM_WR; k++)
            wr_ok[k] = we[k] && !(ZERO_REG && wa[k*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end

    assign alloc_zero  = ZERO_REG && (alloc_addr == '0);
    assign alloc_ready = !alloc_valid || !busy[alloc_addr] || alloc_zero;
    assign alloc_acc   = alloc_valid && alloc_ready;

    // Clears from writes first, then the accepted alloc sets, so a new producer wins.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < NUM_WR; k++)
            if (we[k])
                busy_next[wa[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        if (alloc_acc && !alloc_zero)
            busy_next[alloc_addr] = 1'b1;
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        logic                  hit;
        a       = '0;
        hit     = 1'b0;
        rd      = '0;
        rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            a   = ra[j*ADDR_WIDTH +: ADDR_WIDTH];
            hit = 1'b0;
            rd[j*DATA_WIDTH +: DATA_WIDTH] = regs[a];
            rd_busy[j] = busy[a];
            // Ascending scan leaves the highest-indexed matching port in place.
            for (int k = 0; k < NUM_WR; k++) begin
                if (BYPASS && wr_ok[k] && wa[k*ADDR_WIDTH +: ADDR_WIDTH] == a) begin
                    rd[j*DATA_WIDTH +: DATA_WIDTH] = wd[k*DATA_WIDTH +: DATA_WIDTH];
                    hit = 1'b1;
                end
            end
            if (ZERO_REG && a == '0)
                rd[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            if (hit && !(alloc_acc && !alloc_zero && alloc_addr == a))
                rd_busy[j] = 1'b0;
        end
    end

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++)
                if (wr_ok[k])
                    regs[wa[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wd[k*DATA_WIDTH +: DATA_WIDTH];
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: storage, bypass, x0 handling, scoreboard and reset.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;

    logic             clk;
    logic             reset;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rd_busy;
    logic             alloc_valid;
    logic [AW-1:0]    alloc_addr;
    logic             alloc_ready;
    logic [AW:0]      busy_count;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_data;

    int checks = 0;
    int errors = 0;

    regfile_mp_sb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(1 << AW),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .rd_busy(rd_busy), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_ready(alloc_ready), .busy_count(busy_count),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        wa = '0; wd = '0; alloc_addr = 5'd3; dbg_addr = 5'd5;
        ra = {5'd7, 5'd0, 5'd5};
        #12;
        alloc_valid = 1'b1;
        #1;
        checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL reset_rd_busy: got %b want 000", rd_busy); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count: got %0d want 0", busy_count); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg: got %h want 0", dbg_data); end
        alloc_valid = 1'b0;
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        we = 2'b01; wa[0 +: AW] = 5'd5; wd[0 +: DW] = 32'hDEADBEEF;
        ra[0 +: AW] = 5'd5; dbg_addr = 5'd5;
        #1;
        checks++; if (rd[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bypass_rd0: got %h want deadbeef", rd[0 +: DW]); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL wr_dbg_no_bypass: got %h want 0", dbg_data); end
        tick();
        idle();
        #1;
        checks++; if (rd[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_stored_rd0: got %h want deadbeef", rd[0 +: DW]); end
        checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_stored_dbg: got %h want deadbeef", dbg_data); end
    endtask

    task automatic test_multi_write();
        we = 2'b11;
        wa[0 +: AW] = 5'd7; wd[0 +: DW] = 32'h11111111;
        wa[AW +: AW] = 5'd7; wd[DW +: DW] = 32'h22222222;
        ra[AW +: AW] = 5'd7; dbg_addr = 5'd7;
        #1;
        checks++; if (rd[DW +: DW] !== 32'h22222222) begin errors++; $display("FAIL mw_bypass_rd1: got %h want 22222222", rd[DW +: DW]); end
        tick();
        idle();
        #1;
        checks++; if (dbg_data !== 32'h22222222) begin errors++; $display("FAIL mw_stored_dbg: got %h want 22222222", dbg_data); end
        checks++; if (rd[DW +: DW] !== 32'h22222222) begin errors++; $display("FAIL mw_stored_rd1: got %h want 22222222", rd[DW +: DW]); end
    endtask

    task automatic test_zero_reg();
        we = 2'b01; wa[0 +: AW] = 5'd0; wd[0 +: DW] = 32'hFFFFFFFF;
        ra[0 +: AW] = 5'd0;
        #1;
        checks++; if (rd[0 +: DW] !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rd[0 +: DW]); end
        tick();
        idle();
        dbg_addr = 5'd0;
        alloc_valid = 1'b1; alloc_addr = 5'd0;
        #1;
        checks++; if (rd[0 +: DW] !== 32'h0) begin errors++; $display("FAIL x0_stored: got %h want 0", rd[0 +: DW]); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL x0_dbg: got %h want 0", dbg_data); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL x0_alloc_ready: got %b want 1", alloc_ready); end
        tick();
        idle();
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL x0_busy_count: got %0d want 0", busy_count); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL x0_rd_busy: got %b want 0", rd_busy[0]); end
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL sb_first_alloc: got %b want 1", alloc_ready); end
        tick();
        alloc_valid = 1'b0; ra[2*AW +: AW] = 5'd3;
        #1;
        checks++; if (rd_busy[2] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy_set: got %b want 1", rd_busy[2]); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL sb_count_1: got %0d want 1", busy_count); end
        alloc_valid = 1'b1;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_refuse: got %b want 0", alloc_ready); end
        tick();
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL sb_count_held: got %0d want 1", busy_count); end
        we = 2'b01; wa[0 +: AW] = 5'd3; wd[0 +: DW] = 32'h42;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL sb_pre_edge_busy: got %b want 0", alloc_ready); end
        checks++; if (rd_busy[2] !== 1'b0) begin errors++; $display("FAIL sb_bypass_busy: got %b want 0", rd_busy[2]); end
        checks++; if (rd[2*DW +: DW] !== 32'h42) begin errors++; $display("FAIL sb_bypass_rd2: got %h want 42", rd[2*DW +: DW]); end
        tick();
        we = '0;
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL sb_cleared: got %0d want 0", busy_count); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL sb_retry_accept: got %b want 1", alloc_ready); end
        tick();
        alloc_valid = 1'b0;
        #1;
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL sb_realloc_count: got %0d want 1", busy_count); end
        checks++; if (rd_busy[2] !== 1'b1) begin errors++; $display("FAIL sb_realloc_busy: got %b want 1", rd_busy[2]); end
    endtask

    task automatic test_write_alloc_same();
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        tick();
        we = 2'b10; wa[AW +: AW] = 5'd9; wd[DW +: DW] = 32'h99;
        #1;
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL wa_count_2: got %0d want 2", busy_count); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL wa_refuse_x9: got %b want 0", alloc_ready); end
        tick();
        idle();
        ra[0 +: AW] = 5'd9;
        #1;
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL wa_count_dec: got %0d want 1", busy_count); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wa_x9_free: got %b want 0", rd_busy[0]); end
        checks++; if (rd[0 +: DW] !== 32'h99) begin errors++; $display("FAIL wa_x9_data: got %h want 99", rd[0 +: DW]); end
        // free register written and allocated together: the new producer keeps it busy
        we = 2'b01; wa[0 +: AW] = 5'd12; wd[0 +: DW] = 32'h77;
        alloc_valid = 1'b1; alloc_addr = 5'd12; ra[AW +: AW] = 5'd12;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL sw_accept: got %b want 1", alloc_ready); end
        checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sw_pre_busy: got %b want 0", rd_busy[1]); end
        checks++; if (rd[DW +: DW] !== 32'h77) begin errors++; $display("FAIL sw_bypass: got %h want 77", rd[DW +: DW]); end
        tick();
        idle();
        #1;
        checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sw_set_wins: got %b want 1", rd_busy[1]); end
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL sw_count: got %0d want 2", busy_count); end
        checks++; if (rd[DW +: DW] !== 32'h77) begin errors++; $display("FAIL sw_stored: got %h want 77", rd[DW +: DW]); end
    endtask

    task automatic test_reset_mid();
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        tick();
        alloc_addr = 5'd6;
        tick();
        alloc_valid = 1'b0;
        we = 2'b01; wa[0 +: AW] = 5'd10; wd[0 +: DW] = 32'h5;
        tick();
        we = '0; ra[0 +: AW] = 5'd10; ra[AW +: AW] = 5'd4;
        #1;
        checks++; if (busy_count !== 6'd4) begin errors++; $display("FAIL rm_count_4: got %0d want 4", busy_count); end
        checks++; if (rd[0 +: DW] !== 32'h5) begin errors++; $display("FAIL rm_x10_before: got %h want 5", rd[0 +: DW]); end
        #2 reset = 1'b1;
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL rm_count_0: got %0d want 0", busy_count); end
        checks++; if (rd[0 +: DW] !== 32'h0) begin errors++; $display("FAIL rm_x10_cleared: got %h want 0", rd[0 +: DW]); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rm_alloc_ready: got %b want 1", alloc_ready); end
        checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL rm_x4_free: got %b want 0", rd_busy[1]); end
        alloc_valid = 1'b0;
        #1 reset = 1'b0;
        tick();
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL rm_after_release: got %0d want 0", busy_count); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_multi_write();
        test_zero_reg();
        test_scoreboard();
        test_write_alloc_same();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the next-generation pipelined RV32I core; replaces the single-write/two-read file.
- Provides N combinational read ports and M synchronous write ports.
- Optional write-to-read bypass and an integrated busy-bit scoreboard, so decode can detect RAW/WAW hazards without external tracking.
- Sits in decode/writeback; also carries a debug read port for the testbench.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register address width
NUM_REGS, 1<<ADDR_WIDTH, number of architectural registers
NUM_RD, 3, number of read ports (each has a busy flag)
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
we  in  NUM_WR  per-port write enable
wa  in  NUM_WR*ADDR_WIDTH  write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
wd  in  NUM_WR*DATA_WIDTH  write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
ra  in  NUM_RD*ADDR_WIDTH  read addresses, packed as above
rd  out  NUM_RD*DATA_WIDTH  read data, packed as above
rd_busy  out  NUM_RD  busy bit of register addressed by each read port
alloc_valid  in  1  request to mark a destination register busy (instruction issue)
alloc_addr  in  ADDR_WIDTH  destination to reserve
alloc_ready  out  1  allocation accepted this cycle
busy_count  out  ADDR_WIDTH+1  number of registers currently busy
dbg_addr  in  ADDR_WIDTH  debug read address
dbg_data  out  DATA_WIDTH  debug read data (stored value, never bypassed)

Behaviour:
- Reset (asynchronous, active-high): all registers = 0, all busy bits = 0, busy_count = 0. Read outputs then follow combinationally: rd = 0, rd_busy = 0, alloc_ready = 1, dbg_data = 0.
- Write: on rising clk, for each k with we[k]=1, regs[wa[k]] <= wd[k].
  - If ZERO_REG=1 and wa[k]==0, the write is ignored.
  - Multiple ports writing the same address in one cycle: the highest-indexed port wins.
- Read: combinational; rd[j] = regs[ra[j]], except:
  - ZERO_REG=1 and ra[j]==0 -> 0.
  - BYPASS=1 and some we[k] with wa[k]==ra[j] (non-zero when ZERO_REG=1) -> wd of the highest-indexed matching port.
- Scoreboard: one busy bit per register.
  - alloc_ready = !alloc_valid | !busy[alloc_addr] | (ZERO_REG & alloc_addr==0).
  - Allocating a register that is already busy is refused: alloc_ready=0 and busy is unchanged. This is a WAW stall; the requester holds alloc_valid/alloc_addr until accepted.
  - Accepted allocation to a non-zero address sets busy on the next edge. Allocation to x0 with ZERO_REG=1 is accepted with no effect.
  - Any write (we[k]) to address a clears busy[a] on the next edge.
  - Same cycle, write clears a and alloc sets a: set wins (new producer), busy stays 1. The alloc is accepted only if a was not busy before the edge. With BYPASS, the write clearing a busy a is visible through the read path, but alloc_ready still uses the pre-edge busy value.
- rd_busy[j] = busy[ra[j]], combinational, pre-edge value. With BYPASS=1, rd_busy[j] is forced 0 when a same-cycle write matches ra[j] and no same-cycle accepted alloc targets it.
- busy_count: registered, equals the popcount of busy bits after each edge; maximum NUM_REGS-1 when ZERO_REG=1.
- Reset asserted mid-operation clears storage and scoreboard immediately; in-flight allocations are lost.
- Latency: read 0 cycles; write and busy update visible 1 cycle after the edge (0 cycles via bypass).

Test Plan:
- Reset, then write x5=0xDEADBEEF on port0; next cycle ra0=5 -> rd0=0xDEADBEEF, dbg_addr=5 -> dbg_data=0xDEADBEEF.
- Port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in the same cycle -> x7=0x22222222. Same cycle with BYPASS=1, ra1=7 -> rd1=0x22222222 before the edge.
- Write x0=0xFFFFFFFF -> rd for ra=0 returns 0. alloc x0 -> alloc_ready=1, busy_count stays 0.
- alloc x3 -> next cycle rd_busy=1 for ra=3, busy_count=1. Second alloc x3 -> alloc_ready=0. Write x3=0x42 -> busy clears and alloc x3 is then accepted.
- Same-cycle write x9 (busy) plus alloc x9 -> alloc_ready=0. Next cycle busy[9]=0, busy_count decremented by 1.
- alloc x4 and x6, write x10=0x5, then assert reset mid-cycle -> busy_count=0, rd of x10=0, alloc_ready=1 immediately.
